// File: rtl/fifo_pkt_streamer.sv
// FWFT FIFO consumer: re-emits words as a registered valid/ready stream
// through a 2-entry skid buffer, framing packets of PKT_LEN beats.
module fifo_pkt_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  pkt_done,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t state, state_nxt;

  logic                  load;
  logic                  pop;
  logic                  tag_last;
  logic [BW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_last;
  logic                  out_ld_fifo;
  logic                  out_ld_skid;
  logic                  skid_ld;

  // rd_en depends only on registered state, never on m_ready
  assign load       = ~fifo_empty & (state != S_TWO) & ~clr;
  assign fifo_rd_en = load;
  assign m_valid    = (state != S_EMPTY);
  assign pop        = m_valid & m_ready;
  assign tag_last   = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    out_ld_fifo = 1'b0;
    out_ld_skid = 1'b0;
    skid_ld     = 1'b0;
    if (clr) begin
      state_nxt = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (load) begin
            state_nxt   = S_ONE;
            out_ld_fifo = 1'b1;
          end
        end
        S_ONE: begin
          if (load && pop) begin
            out_ld_fifo = 1'b1;
          end else if (load) begin
            state_nxt = S_TWO;
            skid_ld   = 1'b1;
          end else if (pop) begin
            state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_nxt   = S_ONE;
            out_ld_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
    end else if (load) begin
      beat_cnt <= tag_last ? '0 : beat_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data    <= '0;
      m_last    <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else if (clr) begin
      m_last    <= 1'b0;
      skid_last <= 1'b0;
    end else begin
      if (out_ld_fifo) begin
        m_data <= fifo_dout;
        m_last <= tag_last;
      end else if (out_ld_skid) begin
        m_data <= skid_data;
        m_last <= skid_last;
      end
      if (skid_ld) begin
        skid_data <= fifo_dout;
        skid_last <= tag_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_done <= 1'b0;
      pkt_cnt  <= '0;
    end else if (clr) begin
      pkt_done <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      pkt_done <= pop & m_last;
      if (pop && m_last) begin
        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_streamer.sv
// Bench for fifo_pkt_streamer: cycle table plus FIFO-model sequences
// (PKT_LEN=4 main instance, PKT_LEN=1/CNT_WIDTH=2 wrap instance).
module tb_fifo_pkt_streamer;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        pkt_done;
  logic [15:0] pkt_cnt;

  logic        clr2;
  logic [7:0]  fifo_dout2;
  logic        fifo_empty2;
  logic        fifo_rd_en2;
  logic        m_valid2;
  logic        m_ready2;
  logic [7:0]  m_data2;
  logic        m_last2;
  logic        pkt_done2;
  logic [1:0]  pkt_cnt2;

  fifo_pkt_streamer #(
    .DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
  );

  fifo_pkt_streamer #(
    .DATA_WIDTH(8), .PKT_LEN(1), .CNT_WIDTH(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2),
    .fifo_dout(fifo_dout2), .fifo_empty(fifo_empty2),
    .fifo_rd_en(fifo_rd_en2), .m_valid(m_valid2),
    .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
    .pkt_done(pkt_done2), .pkt_cnt(pkt_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       e;
    logic [7:0] d;
    logic       r;
    logic       c;
    logic       rd;
    logic       v;
    logic [7:0] q;
    logic       l;
    logic       dn;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[17];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  logic hold = 1'b1;
  logic [7:0] q[$];
  logic [8:0] acc[$];
  int acc_cyc[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    fifo_empty = (q.size() == 0) || hold;
    fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = fifo_rd_en;
    if (m_valid && m_ready) begin
      acc.push_back({m_last, m_data});
      acc_cyc.push_back(cyc);
    end
    if (pkt_done) done_seen++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) void'(q.pop_front());
    drive();
  endtask

  task automatic do_reset();
    hold = 1'b1;
    clr  = 1'b0;
    drive();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hold = 1'b0;
    q.delete();
    acc.delete();
    acc_cyc.delete();
    done_seen = 0;
  endtask

  initial begin
    int bad;
    int seen;
    logic [1:0] wrap_exp[5];

    // e d r c | rd v data last done cnt
    tbl[0]  = '{0, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 0, 16'd0};
    tbl[1]  = '{0, 8'h01, 0, 0, 1, 1, 8'hA5, 0, 0, 16'd0};
    tbl[2]  = '{0, 8'h02, 0, 0, 0, 1, 8'hA5, 0, 0, 16'd0};
    tbl[3]  = '{0, 8'h02, 1, 0, 0, 1, 8'h01, 0, 0, 16'd0};
    tbl[4]  = '{0, 8'h02, 1, 0, 1, 1, 8'h02, 0, 0, 16'd0};
    tbl[5]  = '{0, 8'h03, 1, 0, 1, 1, 8'h03, 1, 0, 16'd0};
    tbl[6]  = '{1, 8'h00, 0, 0, 0, 1, 8'h03, 1, 0, 16'd0};
    tbl[7]  = '{1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 16'd1};
    tbl[8]  = '{1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 16'd1};
    tbl[9]  = '{0, 8'h10, 0, 0, 1, 1, 8'h10, 0, 0, 16'd1};
    tbl[10] = '{0, 8'h11, 0, 0, 1, 1, 8'h10, 0, 0, 16'd1};
    tbl[11] = '{0, 8'h12, 0, 1, 0, 0, 8'h00, 0, 0, 16'd0};
    tbl[12] = '{0, 8'h20, 1, 0, 1, 1, 8'h20, 0, 0, 16'd0};
    tbl[13] = '{0, 8'h21, 1, 0, 1, 1, 8'h21, 0, 0, 16'd0};
    tbl[14] = '{0, 8'h22, 1, 0, 1, 1, 8'h22, 0, 0, 16'd0};
    tbl[15] = '{0, 8'h23, 1, 0, 1, 1, 8'h23, 1, 0, 16'd0};
    tbl[16] = '{1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 16'd1};

    clr = 0; clr2 = 0;
    fifo_empty2 = 1; fifo_dout2 = 0; m_ready2 = 0;
    rst_n = 0; m_ready = 0;
    fifo_empty = 0; fifo_dout = 8'hA5;

    // reset held with FIFO non-empty
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_done", 32'(pkt_done), 0);
    rst_n = 1;

    for (int i = 0; i < 17; i++) begin
      fifo_empty = tbl[i].e;
      fifo_dout  = tbl[i].d;
      m_ready    = tbl[i].r;
      clr        = tbl[i].c;
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].rd));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("v%0d_data", i), 32'(m_data), 32'(tbl[i].q));
        chk($sformatf("v%0d_last", i), 32'(m_last), 32'(tbl[i].l));
      end
      chk($sformatf("v%0d_done", i), 32'(pkt_done), 32'(tbl[i].dn));
      chk($sformatf("v%0d_cnt", i), 32'(pkt_cnt), 32'(tbl[i].cnt));
    end
    clr = 0;

    // streaming 8 words, full throughput
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'(i));
    m_ready = 1;
    drive();
    repeat (12) tick();
    chk("stream_count", 32'(acc.size()), 8);
    bad = 0;
    for (int i = 0; i < acc.size(); i++) begin
      if (acc[i] !== {(i % 4 == 3), 8'(i)}) bad++;
      if (acc_cyc[i] != acc_cyc[0] + i) bad++;
    end
    chk("stream_order_last_gaps", 32'(bad), 0);
    chk("stream_done_pulses", 32'(done_seen), 2);
    chk("stream_pkt_cnt", 32'(pkt_cnt), 2);

    // backpressure: exactly two words buffered
    do_reset();
    for (int i = 0; i < 6; i++) q.push_back(8'h30 + 8'(i));
    m_ready = 0;
    drive();
    tick();
    bad = 0;
    repeat (4) begin
      tick();
      if (m_data !== 8'h30) bad++;
    end
    #1;
    chk("bp_data_stable", 32'(bad), 0);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_rd_en", 32'(fifo_rd_en), 0);
    chk("bp_fifo_left", 32'(q.size()), 4);
    m_ready = 1;
    for (int n = 0; n < 20 && acc.size() < 6; n++) tick();
    chk("bp_count", 32'(acc.size()), 6);
    bad = 0;
    for (int i = 0; i < acc.size(); i++) begin
      if (acc[i][7:0] !== 8'h30 + 8'(i)) bad++;
      if (acc_cyc[i] != acc_cyc[0] + i) bad++;
    end
    chk("bp_order_gaps", 32'(bad), 0);

    // random ready / empty toggling, 1000 words
    do_reset();
    for (int i = 0; i < 1000; i++) q.push_back(8'(i));
    for (int n = 0; n < 20000 && acc.size() < 1000; n++) begin
      m_ready = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 2) == 0);
      drive();
      tick();
    end
    hold = 0;
    m_ready = 0;
    drive();
    repeat (3) tick();
    chk("rand_count", 32'(acc.size()), 1000);
    bad = 0;
    for (int i = 0; i < acc.size(); i++) begin
      if (acc[i] !== {(i % 4 == 3), 8'(i)}) bad++;
    end
    chk("rand_order_last", 32'(bad), 0);
    chk("rand_done_pulses", 32'(done_seen), 250);
    chk("rand_pkt_cnt", 32'(pkt_cnt), 250);

    // async reset mid-packet
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'h40 + 8'(i));
    m_ready = 1;
    drive();
    repeat (7) tick();
    chk("ar_pre_cnt", 32'(pkt_cnt), 1);
    q.push_back(8'h44);
    q.push_back(8'h45);
    m_ready = 0;
    drive();
    repeat (3) tick();
    hold = 1;
    drive();
    #2 rst_n = 0;
    #1;
    chk("ar_valid", 32'(m_valid), 0);
    chk("ar_pkt_cnt", 32'(pkt_cnt), 0);
    chk("ar_last", 32'(m_last), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    hold = 0;
    q.delete();
    acc.delete();
    acc_cyc.delete();
    for (int i = 0; i < 4; i++) q.push_back(8'h50 + 8'(i));
    m_ready = 1;
    drive();
    repeat (8) tick();
    chk("ar_count", 32'(acc.size()), 4);
    if (acc.size() == 4) begin
      chk("ar_beat2", 32'(acc[2]), {23'd0, 1'b0, 8'h52});
      chk("ar_beat3", 32'(acc[3]), {23'd0, 1'b1, 8'h53});
    end

    // pkt_cnt wrap on the PKT_LEN=1, CNT_WIDTH=2 instance
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    seen = 0;
    m_ready2 = 1;
    for (int n = 0; n < 20 && seen < 5; n++) begin
      fifo_empty2 = (n >= 5);
      fifo_dout2  = 8'h60 + 8'(n);
      @(negedge clk);
      if (pkt_done2) begin
        chk($sformatf("wrap_cnt%0d", seen), 32'(pkt_cnt2),
            32'(wrap_exp[seen]));
        seen++;
      end
      @(posedge clk);
      #1;
    end
    chk("wrap_pulses", 32'(seen), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
